// File: rtl/ram_wport_arbiter.sv
// Shares the single RAM write port between NREQ datapath requesters and the debug loader.
// Debug writes always win; requesters rotate round-robin with optional bounded locked bursts.
module ram_wport_arbiter #(
    parameter int unsigned NREQ      = 2,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     dbg_wr_en,
    input  logic [ADDR_W-1:0]        dbg_wr_addr,
    input  logic [DATA_W-1:0]        dbg_wr_data,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          req_lock,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          gnt,
    output logic [ADDR_W-1:0]        waddr,
    output logic [DATA_W-1:0]        wdata,
    output logic                     wen,
    output logic                     busy
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t             state, state_d;
    logic [PTR_W-1:0]   ptr, ptr_d;
    logic [PTR_W-1:0]   owner, owner_d;
    logic [CNT_W-1:0]   burst_cnt, burst_cnt_d;
    logic               wen_d;
    logic [ADDR_W-1:0]  waddr_d;
    logic [DATA_W-1:0]  wdata_d;
    logic               found;
    logic [PTR_W-1:0]   sel;
    logic [PTR_W-1:0]   cand;

    logic [ADDR_W-1:0]  addr_arr [NREQ];
    logic [DATA_W-1:0]  data_arr [NREQ];

    // Unflatten the per-requester address/data buses
    always_comb begin
        for (int i = 0; i < int'(NREQ); i++) begin
            addr_arr[i] = req_addr[i*int'(ADDR_W) +: ADDR_W];
            data_arr[i] = req_data[i*int'(DATA_W) +: DATA_W];
        end
    end

    // Next-state, grant and write-port selection
    always_comb begin
        state_d     = state;
        ptr_d       = ptr;
        owner_d     = owner;
        burst_cnt_d = burst_cnt;
        gnt         = '0;
        wen_d       = 1'b0;
        waddr_d     = waddr;
        wdata_d     = wdata;
        found       = 1'b0;
        sel         = '0;
        cand        = '0;

        if (!rst) begin
            if (dbg_wr_en) begin
                wen_d   = 1'b1;
                waddr_d = dbg_wr_addr;
                wdata_d = dbg_wr_data;
            end else if (state == LOCKED && req[owner] && burst_cnt < CNT_W'(MAX_BURST)) begin
                gnt[owner]  = 1'b1;
                wen_d       = 1'b1;
                waddr_d     = addr_arr[owner];
                wdata_d     = data_arr[owner];
                burst_cnt_d = burst_cnt + CNT_W'(1);
                if (!req_lock[owner] || burst_cnt_d == CNT_W'(MAX_BURST)) begin
                    state_d = IDLE;
                end
            end else begin
                // Lock (if any) is released this cycle, so the search runs immediately
                state_d = IDLE;
                for (int k = 0; k < int'(NREQ); k++) begin
                    cand = PTR_W'((int'(ptr) + k) % int'(NREQ));
                    if (!found && req[cand]) begin
                        found = 1'b1;
                        sel   = cand;
                    end
                end
                if (found) begin
                    gnt[sel] = 1'b1;
                    wen_d    = 1'b1;
                    waddr_d  = addr_arr[sel];
                    wdata_d  = data_arr[sel];
                    ptr_d    = PTR_W'((int'(sel) + 1) % int'(NREQ));
                    if (req_lock[sel] && MAX_BURST > 1) begin
                        state_d     = LOCKED;
                        owner_d     = sel;
                        burst_cnt_d = CNT_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            burst_cnt <= '0;
            wen       <= 1'b0;
            waddr     <= '0;
            wdata     <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            ptr       <= ptr_d;
            owner     <= owner_d;
            burst_cnt <= burst_cnt_d;
            wen       <= wen_d;
            waddr     <= waddr_d;
            wdata     <= wdata_d;
            busy      <= (state_d == LOCKED);
        end
    end

endmodule
